// File: rtl/uart_fifo_bridge_if.sv
// Host FIFO access and Uart handshake signals of uart_fifo_bridge.
// The master modport is the host/Uart side; the slave modport is the bridge.
interface uart_fifo_bridge_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             txWrite;
  logic [WIDTH-1:0] txWriteData;
  logic             txFull;
  logic [CW-1:0]    txCount;
  logic             rxRead;
  logic [WIDTH-1:0] rxReadData;
  logic             rxEmpty;
  logic [CW-1:0]    rxCount;
  logic             rxOverrun;
  logic             rxError;
  logic             clearErrors;
  logic             uartStartTx;
  logic [WIDTH-1:0] uartTxData;
  logic             uartTxIdle;
  logic             uartRxFull;
  logic             uartFrameError;
  logic             uartParityError;
  logic [WIDTH-1:0] uartRxData;

  modport master (
    output txWrite, txWriteData, rxRead, clearErrors, uartTxIdle,
           uartRxFull, uartFrameError, uartParityError, uartRxData,
    input  txFull, txCount, rxReadData, rxEmpty, rxCount, rxOverrun,
           rxError, uartStartTx, uartTxData
  );

  modport slave (
    input  txWrite, txWriteData, rxRead, clearErrors, uartTxIdle,
           uartRxFull, uartFrameError, uartParityError, uartRxData,
    output txFull, txCount, rxReadData, rxEmpty, rxCount, rxOverrun,
           rxError, uartStartTx, uartTxData
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Host-side TX/RX FIFOs in front of a 9-bit Uart: TX FSM feeds the Uart one
// character per transfer, RX side captures a character on each uartRxFull rise.
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input logic               clk,
  input logic               reset,
  uart_fifo_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {TxIdle, TxWaitBusy, TxWaitIdle} tx_state_e;

  logic [WIDTH-1:0] txMem_q [DEPTH];
  logic [AW-1:0]    txWrPtr_q, txRdPtr_q;
  logic [CW-1:0]    txCnt_q, txCnt_d;
  logic             txPush, txPop;
  tx_state_e        txState_q;
  logic [WIDTH-1:0] txHold_q;
  logic             txStart_q;

  logic [WIDTH-1:0] rxMem_q [DEPTH];
  logic [AW-1:0]    rxWrPtr_q, rxRdPtr_q;
  logic [CW-1:0]    rxCnt_q, rxCnt_d;
  logic             rxFullLvl_q, frameLvl_q, parityLvl_q;
  logic             overrun_q, overrun_d, error_q, error_d;
  logic             rxEdge, rxPop, rxPush, errEdge;

  assign txPush = bus.txWrite && (txCnt_q != FULL);
  assign txPop  = (txState_q == TxIdle) && (txCnt_q != '0) && bus.uartTxIdle;

  always_comb txCnt_d = txCnt_q + CW'(txPush) - CW'(txPop);

  always_ff @(posedge clk) begin
    if (txPush) txMem_q[txWrPtr_q] <= bus.txWriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      txCnt_q   <= '0;
    end else begin
      if (txPush) txWrPtr_q <= txWrPtr_q + AW'(1);
      if (txPop)  txRdPtr_q <= txRdPtr_q + AW'(1);
      txCnt_q <= txCnt_d;
    end
  end

  // A transfer ends only after the Uart has been seen busy and then idle again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txState_q <= TxIdle;
      txHold_q  <= '0;
      txStart_q <= 1'b0;
    end else begin
      txStart_q <= 1'b0;
      case (txState_q)
        TxIdle: if (txPop) begin
          txHold_q  <= txMem_q[txRdPtr_q];
          txStart_q <= 1'b1;
          txState_q <= TxWaitBusy;
        end
        TxWaitBusy: if (!bus.uartTxIdle) txState_q <= TxWaitIdle;
        TxWaitIdle: if (bus.uartTxIdle)  txState_q <= TxIdle;
        default:    txState_q <= TxIdle;
      endcase
    end
  end

  // When full, a push still fits if the head leaves in the same cycle.
  assign rxEdge  = bus.uartRxFull && !rxFullLvl_q;
  assign rxPop   = bus.rxRead && (rxCnt_q != '0);
  assign rxPush  = rxEdge && ((rxCnt_q != FULL) || rxPop);
  assign errEdge = (bus.uartFrameError && !frameLvl_q) ||
                   (bus.uartParityError && !parityLvl_q);

  always_comb begin
    rxCnt_d   = rxCnt_q + CW'(rxPush) - CW'(rxPop);
    overrun_d = (rxEdge && !rxPush) || (overrun_q && !bus.clearErrors);
    error_d   = errEdge || (error_q && !bus.clearErrors);
  end

  always_ff @(posedge clk) begin
    if (rxPush) rxMem_q[rxWrPtr_q] <= bus.uartRxData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxWrPtr_q   <= '0;
      rxRdPtr_q   <= '0;
      rxCnt_q     <= '0;
      rxFullLvl_q <= 1'b0;
      frameLvl_q  <= 1'b0;
      parityLvl_q <= 1'b0;
      overrun_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + AW'(1);
      if (rxPop)  rxRdPtr_q <= rxRdPtr_q + AW'(1);
      rxCnt_q     <= rxCnt_d;
      rxFullLvl_q <= bus.uartRxFull;
      frameLvl_q  <= bus.uartFrameError;
      parityLvl_q <= bus.uartParityError;
      overrun_q   <= overrun_d;
      error_q     <= error_d;
    end
  end

  assign bus.txFull      = (txCnt_q == FULL);
  assign bus.txCount     = txCnt_q;
  assign bus.uartStartTx = txStart_q;
  assign bus.uartTxData  = txHold_q;
  assign bus.rxReadData  = rxMem_q[rxRdPtr_q];
  assign bus.rxEmpty     = (rxCnt_q == '0);
  assign bus.rxCount     = rxCnt_q;
  assign bus.rxOverrun   = overrun_q;
  assign bus.rxError     = error_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: queue-based model checked every cycle,
// plus literal expectations for each scenario and a simple Uart transfer model.
module tb_uart_fifo_bridge;
  localparam int DEPTH    = 16;
  localparam int WIDTH    = 9;
  localparam int UART_CYC = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  uart_fifo_bridge_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  uart_fifo_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic holdBusy = 1'b0;
  int ucnt = 0;
  logic [WIDTH-1:0] startLog [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Uart transmitter: busy for UART_CYC cycles after each start pulse.
  initial begin
    bus.uartTxIdle = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.uartStartTx === 1'b1) ucnt = UART_CYC;
      else if (ucnt > 0) ucnt--;
      bus.uartTxIdle = !holdBusy && (ucnt == 0);
    end
  end

  // Behavioural model: FIFOs as queues, a transfer is outstanding from its
  // start until the Uart has gone busy and come back idle.
  logic [WIDTH-1:0] mTx [$];
  logic [WIDTH-1:0] mRx [$];
  logic [WIDTH-1:0] mHold;
  bit mStart, mXfer, mSawBusy, mOvr, mErr, pRxFull, pFrame, pPar;
  bit mGo, mWr, mRd, mFull, mEdge;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mTx.delete(); mRx.delete();
      mHold = '0; mStart = 0; mXfer = 0; mSawBusy = 0;
      mOvr = 0; mErr = 0; pRxFull = 0; pFrame = 0; pPar = 0;
    end else begin
      mGo = !mXfer && (mTx.size() > 0) && bus.uartTxIdle;
      mWr = bus.txWrite && (mTx.size() < DEPTH);
      mStart = mGo;
      if (mGo) begin
        mHold = mTx.pop_front(); mXfer = 1; mSawBusy = 0;
      end else if (mXfer) begin
        if (!bus.uartTxIdle) mSawBusy = 1;
        else if (mSawBusy) mXfer = 0;
      end
      if (mWr) mTx.push_back(bus.txWriteData);

      mFull = (mRx.size() == DEPTH);
      mRd   = bus.rxRead && (mRx.size() > 0);
      mEdge = bus.uartRxFull && !pRxFull;
      if (bus.clearErrors) begin mOvr = 0; mErr = 0; end
      if (mRd) void'(mRx.pop_front());
      if (mEdge) begin
        if (!mFull || mRd) mRx.push_back(bus.uartRxData);
        else mOvr = 1;
      end
      if ((bus.uartFrameError && !pFrame) || (bus.uartParityError && !pPar)) mErr = 1;
      pRxFull = bus.uartRxFull; pFrame = bus.uartFrameError; pPar = bus.uartParityError;
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    chk("txCount",     32'(bus.txCount),     32'(mTx.size()));
    chk("txFull",      32'(bus.txFull),      32'(mTx.size() == DEPTH));
    chk("rxCount",     32'(bus.rxCount),     32'(mRx.size()));
    chk("rxEmpty",     32'(bus.rxEmpty),     32'(mRx.size() == 0));
    if (mRx.size() > 0) chk("rxReadData", 32'(bus.rxReadData), 32'(mRx[0]));
    chk("rxOverrun",   32'(bus.rxOverrun),   32'(mOvr));
    chk("rxError",     32'(bus.rxError),     32'(mErr));
    chk("uartStartTx", 32'(bus.uartStartTx), 32'(mStart));
    chk("uartTxData",  32'(bus.uartTxData),  32'(mHold));
    if (bus.uartStartTx === 1'b1) startLog.push_back(bus.uartTxData);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [WIDTH-1:0] d);
    bus.txWrite = 1'b1; bus.txWriteData = d;
    tick();
    bus.txWrite = 1'b0;
  endtask

  task automatic rx_edge(input logic [WIDTH-1:0] d, input int hold);
    bus.uartRxData = d; bus.uartRxFull = 1'b1;
    tick(hold);
    bus.uartRxFull = 1'b0;
    tick();
  endtask

  task automatic rx_pop();
    bus.rxRead = 1'b1;
    tick();
    bus.rxRead = 1'b0;
  endtask

  task automatic clear_err();
    bus.clearErrors = 1'b1;
    tick();
    bus.clearErrors = 1'b0;
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [WIDTH-1:0] exp3 [3];
    exp3[0] = 9'h041; exp3[1] = 9'h042; exp3[2] = 9'h043;
    bus.txWrite = 0; bus.txWriteData = '0; bus.rxRead = 0; bus.clearErrors = 0;
    bus.uartRxFull = 0; bus.uartFrameError = 0; bus.uartParityError = 0; bus.uartRxData = '0;

    tick(3);
    chk("rst txCount",     32'(bus.txCount), 0);
    chk("rst txFull",      32'(bus.txFull), 0);
    chk("rst rxEmpty",     32'(bus.rxEmpty), 1);
    chk("rst rxCount",     32'(bus.rxCount), 0);
    chk("rst uartStartTx", 32'(bus.uartStartTx), 0);
    chk("rst uartTxData",  32'(bus.uartTxData), 0);
    chk("rst rxOverrun",   32'(bus.rxOverrun), 0);
    chk("rst rxError",     32'(bus.rxError), 0);
    rst_n = 1'b1;
    tick(2);

    // Three characters through the Uart, in order.
    startLog.delete();
    tx_push(9'h041); tx_push(9'h042); tx_push(9'h043);
    for (int i = 0; i < 100 && startLog.size() < 3; i++) tick();
    tick(UART_CYC + 4);
    chk("tx start count", 32'(startLog.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("tx start data", (i < startLog.size()) ? 32'(startLog[i]) : 32'hDEAD, 32'(exp3[i]));

    // Uart held busy: DEPTH+1 pushes, last one lost.
    holdBusy = 1'b1;
    tick(2);
    startLog.delete();
    for (int i = 0; i <= DEPTH; i++) tx_push(9'h100 + 9'(i));
    tick();
    chk("tx full flag",  32'(bus.txFull), 1);
    chk("tx full count", 32'(bus.txCount), DEPTH);
    chk("tx no start while busy", 32'(startLog.size()), 0);
    holdBusy = 1'b0;
    for (int i = 0; i < 400 && startLog.size() < DEPTH; i++) tick();
    tick(30);
    chk("tx drained starts", 32'(startLog.size()), DEPTH);
    chk("tx last char", (startLog.size() > 0) ? 32'(startLog[startLog.size()-1]) : 32'hDEAD, 32'h10F);
    chk("tx drained count", 32'(bus.txCount), 0);

    // RX: two characters, level held high 10 cycles each.
    rx_edge(9'h0AA, 10);
    rx_edge(9'h155, 10);
    chk("rx count 2", 32'(bus.rxCount), 2);
    chk("rx first",   32'(bus.rxReadData), 32'h0AA);
    rx_pop();
    chk("rx second",  32'(bus.rxReadData), 32'h155);
    rx_pop();
    chk("rx empty",   32'(bus.rxEmpty), 1);
    rx_pop();
    chk("rx read while empty", 32'(bus.rxCount), 0);

    // RX full: overrun on a bare edge, no loss with a simultaneous read.
    for (int i = 0; i < DEPTH; i++) rx_edge(9'h010 + 9'(i), 1);
    chk("rx full count", 32'(bus.rxCount), DEPTH);
    rx_edge(9'h1FF, 1);
    chk("rx overrun",       32'(bus.rxOverrun), 1);
    chk("rx overrun count", 32'(bus.rxCount), DEPTH);
    chk("rx overrun head",  32'(bus.rxReadData), 32'h010);
    bus.uartRxData = 9'h1EE; bus.uartRxFull = 1'b1; bus.rxRead = 1'b1;
    tick();
    bus.uartRxFull = 1'b0; bus.rxRead = 1'b0;
    tick();
    chk("rx push+read count", 32'(bus.rxCount), DEPTH);
    chk("rx push+read head",  32'(bus.rxReadData), 32'h011);
    for (int i = 0; i < DEPTH - 1; i++) rx_pop();
    chk("rx wrapped tail", 32'(bus.rxReadData), 32'h1EE);
    rx_pop();
    chk("rx drained", 32'(bus.rxEmpty), 1);
    clear_err();
    chk("rx overrun cleared", 32'(bus.rxOverrun), 0);

    // Error flags: set beats clear; steady level does not re-set.
    bus.uartParityError = 1'b1; bus.clearErrors = 1'b1;
    tick();
    bus.uartParityError = 1'b0; bus.clearErrors = 1'b0;
    chk("err set over clear", 32'(bus.rxError), 1);
    clear_err();
    chk("err cleared", 32'(bus.rxError), 0);
    bus.uartFrameError = 1'b1;
    tick(3);
    chk("frame err set", 32'(bus.rxError), 1);
    clear_err();
    chk("frame level no reset", 32'(bus.rxError), 0);
    bus.uartFrameError = 1'b0;
    tick();

    // Reset while a transfer is in flight with 3 entries queued.
    tick(10);
    startLog.delete();
    for (int i = 0; i < 4; i++) tx_push(9'h0C0 + 9'(i));
    tick();
    chk("pre-reset count",  32'(bus.txCount), 3);
    chk("pre-reset starts", 32'(startLog.size()), 1);
    rst_n = 1'b0;
    tick();
    chk("reset txCount",     32'(bus.txCount), 0);
    chk("reset uartStartTx", 32'(bus.uartStartTx), 0);
    chk("reset uartTxData",  32'(bus.uartTxData), 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("post-reset start", 32'(bus.uartStartTx), 0);
    chk("post-reset count", 32'(bus.txCount), 0);
    tick(10);
    startLog.delete();
    tx_push(9'h0D5);
    tick(4);
    chk("post-reset restart", 32'(startLog.size()), 1);
    chk("post-reset data", (startLog.size() > 0) ? 32'(startLog[0]) : 32'hDEAD, 32'h0D5);
    tick(UART_CYC + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entries per FIFO; power of two, 2..256.
REQ-002 SHALL have parameter WIDTH, default 9, meaning bits per character, matching the Uart 9-bit data path.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port txWrite  input  1  host push strobe into the TX FIFO.
REQ-006 SHALL have port txWriteData  input  WIDTH  character to push.
REQ-007 SHALL have port txFull  output  1  TX FIFO holds DEPTH entries.
REQ-008 SHALL have port txCount  output  log2(DEPTH)+1  TX FIFO occupancy.
REQ-009 SHALL have port rxRead  input  1  host pop strobe from the RX FIFO.
REQ-010 SHALL have port rxReadData  output  WIDTH  RX FIFO head, first-word-fall-through.
REQ-011 SHALL have port rxEmpty  output  1  RX FIFO holds no entries.
REQ-012 SHALL have port rxCount  output  log2(DEPTH)+1  RX FIFO occupancy.
REQ-013 SHALL have port rxOverrun  output  1  sticky; a character was dropped because the RX FIFO was full.
REQ-014 SHALL have port rxError  output  1  sticky; the Uart reported a frame or parity error.
REQ-015 SHALL have port clearErrors  input  1  clears rxOverrun and rxError.
REQ-016 SHALL have port uartStartTx  output  1  one-cycle start pulse to the Uart.
REQ-017 SHALL have port uartTxData  output  WIDTH  character presented to the Uart.
REQ-018 SHALL have port uartTxIdle  input  1  Uart transmitter idle.
REQ-019 SHALL have ports uartRxFull, uartFrameError and uartParityError  input  1 each  Uart receive status levels.
REQ-020 SHALL have port uartRxData  input  WIDTH  Uart received character.

Function
REQ-021 The TX FSM SHALL have states TxIdle, TxWaitBusy and TxWaitIdle.
REQ-022 In TxIdle with the TX FIFO non-empty and uartTxIdle=1, the block SHALL pop the head into holding register txHold, pulse uartStartTx for exactly one cycle, and go to TxWaitBusy.
REQ-023 uartTxData SHALL be driven from txHold and SHALL remain constant from the start pulse until the FSM returns to TxIdle.
REQ-024 In TxWaitBusy the FSM SHALL move to TxWaitIdle when uartTxIdle=0.
REQ-025 In TxWaitIdle the FSM SHALL move to TxIdle when uartTxIdle=1; the next start pulse SHALL come no earlier than the following cycle.
REQ-026 txWrite SHALL be accepted only when txFull=0 in that cycle; a write while full SHALL be ignored with no state change.
REQ-027 An accepted write and a pop in the same cycle SHALL leave txCount unchanged.
REQ-028 The block SHALL register uartRxFull and push uartRxData only on its 0->1 transition; it SHALL never push on a steady high level.
REQ-029 On a push while the RX FIFO is full without a simultaneous rxRead, the character SHALL be dropped and rxOverrun set.
REQ-030 A push and an rxRead in the same full cycle SHALL both succeed, leaving rxCount=DEPTH.
REQ-031 rxRead while rxEmpty=1 SHALL be ignored; rxReadData is then undefined.
REQ-032 rxError SHALL be set on a 0->1 transition of uartFrameError or uartParityError.
REQ-033 clearErrors SHALL clear both sticky flags; a set event in the same cycle as clearErrors SHALL take priority, leaving the flag at 1.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH; counts SHALL never exceed DEPTH or underflow.

Reset
REQ-035 While reset=0, both FIFOs SHALL be emptied and the TX FSM forced to TxIdle.
REQ-036 While reset=0, the outputs SHALL be uartStartTx=0, uartTxData=0, txFull=0, txCount=0, rxEmpty=1, rxCount=0, rxOverrun=0, rxError=0, and the registered status levels SHALL be 0.
REQ-037 Reset asserted mid-transfer SHALL abort that transfer; no start pulse SHALL be issued until at least one cycle after reset deasserts.

Verification
REQ-038 Push 0x041, 0x042, 0x043 with uartTxIdle modelled by a Uart transfer -> three single-cycle start pulses in order, with uartTxData stable throughout each transfer.
REQ-039 Hold uartTxIdle=0 and push DEPTH+1 characters -> txFull=1, txCount=DEPTH, and the last character is lost.
REQ-040 Give uartRxFull rising edges for 0x0AA and 0x155, with the level held high for 10 cycles each -> rxCount=2, reads return 0x0AA then 0x155.
REQ-041 With the RX FIFO full, give a rising edge and no read -> rxOverrun=1, contents unchanged; give a rising edge plus rxRead in the same cycle -> rxCount stays DEPTH.
REQ-042 Pulse uartParityError in the same cycle as clearErrors -> rxError=1; then clearErrors alone -> rxError=0.
REQ-043 Assert reset during TxWaitIdle with 3 TX entries -> txCount=0, the FSM is in TxIdle, and uartStartTx stays 0.
